blk_5ae238: RTL and testbench

Avalon-ST data-format (width-narrowing) adapter placed directly downstream of the ST adapter's timing-adapter FIFO.
- Accepts one 32-bit beat (4 x 8-bit symbols) with channel, error and packet framing.
- Emits the symbols one per beat on an 8-bit stream toward the narrow sink (e.g. byte-wide UART/JTAG path).
- Preserves packet boundaries, channel and error, and honours backpressure both ways.

---
 rtl/nios_system_avalon_st_pkg.sv | 28 ++
 rtl/blk_5ae238_if.sv | 25 ++
 rtl/blk_5ae238_unpacker.sv | 73 +++++++
 rtl/blk_5ae238.sv | 49 ++++
 tb/tb_blk_5ae238.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/nios_system_avalon_st_pkg.sv
// Shared Avalon-ST widths, beat payload and symbol selection helper.
package nios_system_avalon_st_pkg;

    localparam int unsigned IN_SYMBOLS = 4;
    localparam int unsigned SYMBOL_W   = 8;
    localparam int unsigned CHANNEL_W  = 2;
    localparam int unsigned ERROR_W    = 6;
    localparam int unsigned EMPTY_W    = 2;
    localparam int unsigned DATA_W     = IN_SYMBOLS * SYMBOL_W;

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [CHANNEL_W-1:0] channel;
        logic [ERROR_W-1:0]   error;
        logic                 sop;
        logic                 eop;
        logic [EMPTY_W-1:0]   empty;
    } st_beat;

    // Symbol 0 lives in the high-order bits of the word.
    function automatic logic [SYMBOL_W-1:0] symbol_sel(input logic [DATA_W-1:0] word,
                                                       input logic [EMPTY_W-1:0] idx);
        logic [DATA_W-1:0] w_shift;
        w_shift = word << (SYMBOL_W * 32'(idx));
        return w_shift[DATA_W-1 -: SYMBOL_W];
    endfunction

endpackage

// File: rtl/blk_5ae238_if.sv
// Avalon-ST stream bundle; DATA_W sets the data bus width.
interface blk_5ae238_if
    import nios_system_avalon_st_pkg::*;
#(
    parameter int unsigned DATA_W = 32
);
    logic                 valid;
    logic                 ready;
    logic [DATA_W-1:0]    data;
    logic [CHANNEL_W-1:0] channel;
    logic [ERROR_W-1:0]   error;
    logic                 startofpacket;
    logic                 endofpacket;
    logic [EMPTY_W-1:0]   empty;

    modport master (
        output valid, data, channel, error, startofpacket, endofpacket, empty,
        input  ready
    );

    modport slave (
        input  valid, data, channel, error, startofpacket, endofpacket, empty,
        output ready
    );
endinterface

// File: rtl/blk_5ae238_unpacker.sv
// Holding register, symbol index counter and symbol mux for the width-narrowing adapter.
module nios_system_avalon_st_adapter_001_data_format_adapter_0_unpacker
    import nios_system_avalon_st_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic                 i_advance,
    input  st_beat               i_beat,
    output logic                 o_hold_valid,
    output logic                 o_last_c,
    output logic [SYMBOL_W-1:0]  o_data_c,
    output logic [CHANNEL_W-1:0] o_channel,
    output logic [ERROR_W-1:0]   o_error,
    output logic                 o_sop_c,
    output logic                 o_eop_c
);

    logic                 r_hold_valid;
    logic [EMPTY_W-1:0]   r_sym_idx;
    logic [EMPTY_W-1:0]   r_last_idx;
    logic [DATA_W-1:0]    r_data;
    logic [CHANNEL_W-1:0] r_channel;
    logic [ERROR_W-1:0]   r_error;
    logic                 r_sop;
    logic                 r_eop;

    logic [EMPTY_W-1:0]   w_load_last_idx;
    logic                 w_last;

    // Empty only trims the eop beat; other beats always carry every symbol.
    assign w_load_last_idx = i_beat.eop ? (EMPTY_W'(IN_SYMBOLS - 1) - i_beat.empty)
                                        : EMPTY_W'(IN_SYMBOLS - 1);
    assign w_last          = (r_sym_idx == r_last_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_sym_idx    <= '0;
            r_last_idx   <= '0;
            r_data       <= '0;
            r_channel    <= '0;
            r_error      <= '0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
        end else if (i_load) begin
            r_hold_valid <= 1'b1;
            r_sym_idx    <= '0;
            r_last_idx   <= w_load_last_idx;
            r_data       <= i_beat.data;
            r_channel    <= i_beat.channel;
            r_error      <= i_beat.error;
            r_sop        <= i_beat.sop;
            r_eop        <= i_beat.eop;
        end else if (i_advance) begin
            if (w_last) begin
                r_hold_valid <= 1'b0;
                r_sym_idx    <= '0;
            end else begin
                r_sym_idx    <= r_sym_idx + EMPTY_W'(1);
            end
        end
    end

    assign o_hold_valid = r_hold_valid;
    assign o_last_c     = w_last;
    assign o_data_c     = symbol_sel(r_data, r_sym_idx);
    assign o_channel    = r_channel;
    assign o_error      = r_error;
    assign o_sop_c      = r_sop && (r_sym_idx == '0);
    assign o_eop_c      = r_eop && w_last;

endmodule

// File: rtl/blk_5ae238.sv
// Avalon-ST 32-bit to 8-bit data-format adapter: ready/valid glue around the unpacker.
module blk_5ae238
    import nios_system_avalon_st_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    blk_5ae238_if.slave  st_in,
    blk_5ae238_if.master st_out
);

    st_beat w_beat;
    logic   w_hold_valid;
    logic   w_last;
    logic   w_in_ready;
    logic   w_accept;
    logic   w_advance;

    assign w_beat.data    = st_in.data;
    assign w_beat.channel = st_in.channel;
    assign w_beat.error   = st_in.error;
    assign w_beat.sop     = st_in.startofpacket;
    assign w_beat.eop     = st_in.endofpacket;
    assign w_beat.empty   = st_in.empty;

    // Ready looks through to out_ready on the last symbol so words stream without a bubble.
    assign w_in_ready = !w_hold_valid || (st_out.ready && w_last);
    assign w_accept   = st_in.valid && w_in_ready;
    assign w_advance  = w_hold_valid && st_out.ready;

    assign st_in.ready  = w_in_ready;
    assign st_out.valid = w_hold_valid;
    assign st_out.empty = '0;

    nios_system_avalon_st_adapter_001_data_format_adapter_0_unpacker u_unpacker (
        .clk          (clk),
        .rst_n        (reset_n),
        .i_load       (w_accept),
        .i_advance    (w_advance),
        .i_beat       (w_beat),
        .o_hold_valid (w_hold_valid),
        .o_last_c     (w_last),
        .o_data_c     (st_out.data),
        .o_channel    (st_out.channel),
        .o_error      (st_out.error),
        .o_sop_c      (st_out.startofpacket),
        .o_eop_c      (st_out.endofpacket)
    );

endmodule

// File: tb/tb_blk_5ae238.sv
// Directed bench for blk_5ae238 with a scoreboard of expected output symbols.
module tb_blk_5ae238;

    typedef struct {
        logic [7:0] d;
        logic [1:0] ch;
        logic [5:0] er;
        logic       sop;
        logic       eop;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_xfer = 0;
    int   acc_cyc = 0;

    exp_t sb[$];
    int   xfer_cyc[$];
    logic [7:0] xfer_dat[$];
    logic xfer_rdy[$];

    blk_5ae238_if #(.DATA_W(32)) st_in ();
    blk_5ae238_if #(.DATA_W(8))  st_out ();

    blk_5ae238 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .st_in   (st_in),
        .st_out  (st_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each transfer, checks stability while stalled.
    logic        prev_stall = 1'b0;
    logic [17:0] snap;
    always @(negedge clk) begin
        if (reset_n && st_out.valid) begin
            if (prev_stall)
                check("stall_stable", {st_out.data, st_out.channel, st_out.error,
                                       st_out.startofpacket, st_out.endofpacket}, snap);
            if (st_out.ready) begin
                n_xfer++;
                xfer_cyc.push_back(cyc);
                xfer_dat.push_back(st_out.data);
                xfer_rdy.push_back(st_in.ready);
                check("sb_nonempty", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", st_out.data, e.d);
                    check("out_frame", {st_out.channel, st_out.error, st_out.startofpacket,
                                        st_out.endofpacket}, {e.ch, e.er, e.sop, e.eop});
                end
            end
            prev_stall = !st_out.ready;
            snap = {st_out.data, st_out.channel, st_out.error,
                    st_out.startofpacket, st_out.endofpacket};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_word(input logic [31:0] data, input logic [1:0] ch, input logic [5:0] er,
                             input logic sop, input logic eop, input logic [1:0] empty);
        int n;
        n = eop ? 4 - int'(empty) : 4;
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.d   = data[31-8*i -: 8];
            e.ch  = ch;
            e.er  = er;
            e.sop = sop && (i == 0);
            e.eop = eop && (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send(input logic [31:0] data, input logic [1:0] ch, input logic [5:0] er,
                        input logic sop, input logic eop, input logic [1:0] empty);
        logic got;
        got = 1'b0;
        st_in.valid = 1'b1;
        st_in.data = data;
        st_in.channel = ch;
        st_in.error = er;
        st_in.startofpacket = sop;
        st_in.endofpacket = eop;
        st_in.empty = empty;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (st_in.ready) begin
                acc_cyc = cyc;
                push_word(data, ch, er, sop, eop, empty);
                got = 1'b1;
                break;
            end
        end
        check("accept_in_time", got, 1);
        @(posedge clk);
        #1;
        st_in.valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", sb.size(), 0);
    endtask

    task automatic clear_log();
        xfer_cyc.delete();
        xfer_dat.delete();
        xfer_rdy.delete();
    endtask

    initial begin
        int acc1;
        logic pat [6];
        st_in.valid = 1'b0;
        st_in.data = '0;
        st_in.channel = '0;
        st_in.error = '0;
        st_in.startofpacket = 1'b0;
        st_in.endofpacket = 1'b0;
        st_in.empty = '0;
        st_out.ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", st_out.valid, 0);
        check("rst_in_ready", st_in.ready, 1);
        check("rst_outputs", {st_out.data, st_out.channel, st_out.error,
                              st_out.startofpacket, st_out.endofpacket}, 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single full word
        clear_log();
        send(32'hA1B2C3D4, 2'd2, 6'h00, 1'b1, 1'b1, 2'd0);
        acc1 = acc_cyc;
        drain();
        check("t1_count", xfer_dat.size(), 4);
        check("t1_latency", xfer_cyc[0], acc1 + 1);
        check("t1_contiguous", xfer_cyc[3], acc1 + 4);
        check("t1_rdy_first", xfer_rdy[0], 0);
        check("t1_rdy_last", xfer_rdy[3], 1);

        // 2: back-to-back words
        clear_log();
        send(32'h01020304, 2'd1, 6'h00, 1'b1, 1'b0, 2'd0);
        send(32'h05060708, 2'd1, 6'h00, 1'b0, 1'b1, 2'd0);
        drain();
        check("t2_count", xfer_dat.size(), 8);
        check("t2_no_bubble", xfer_cyc[7] - xfer_cyc[0], 7);
        check("t2_accept_on_04", acc_cyc, xfer_cyc[3]);
        check("t2_beat3_data", xfer_dat[3], 8'h04);

        // 3: eop word with empty=2, next word follows on the last beat
        clear_log();
        send(32'hDEADBEEF, 2'd3, 6'h00, 1'b1, 1'b1, 2'd2);
        send(32'hCAFEF00D, 2'd0, 6'h00, 1'b1, 1'b1, 2'd0);
        drain();
        check("t3_count", xfer_dat.size(), 6);
        check("t3_accept_on_ad", acc_cyc, xfer_cyc[1]);
        check("t3_next_first", xfer_dat[2], 8'hCA);

        // 4: backpressure pattern during a word
        clear_log();
        send(32'hA1B2C3D4, 2'd2, 6'h00, 1'b1, 1'b1, 2'd0);
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0;
        pat[3] = 1'b1; pat[4] = 1'b0; pat[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            st_out.ready = pat[i];
            @(posedge clk);
            #1;
        end
        st_out.ready = 1'b1;
        drain();
        check("t4_count", xfer_dat.size(), 4);
        check("t4_rdy_low", {xfer_rdy[0], xfer_rdy[1], xfer_rdy[2]}, 0);
        check("t4_rdy_last", xfer_rdy[3], 1);

        // 5: error propagation then cleared
        send(32'h0A0B0C0D, 2'd1, 6'h04, 1'b1, 1'b1, 2'd0);
        send(32'h1A1B1C1D, 2'd1, 6'h00, 1'b1, 1'b1, 2'd0);
        drain();

        // 6: asynchronous reset mid-word
        send(32'h55667788, 2'd2, 6'h00, 1'b1, 1'b1, 2'd0);
        acc1 = n_xfer;
        for (int i = 0; i < 20 && n_xfer < acc1 + 2; i++) begin
            @(posedge clk);
            #3;
        end
        check("t6_two_symbols", n_xfer - acc1, 2);
        reset_n = 1'b0;
        #1;
        check("t6_async_valid", st_out.valid, 0);
        check("t6_async_ready", st_in.ready, 1);
        sb.delete();
        #13;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_log();
        send(32'h11223344, 2'd0, 6'h00, 1'b1, 1'b1, 2'd0);
        drain();
        check("t6_count", xfer_dat.size(), 4);
        check("t6_first", xfer_dat[0], 8'h11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
